serial_chunk_adder: RTL

SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

---
 rtl/serial_chunk_adder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder
//   Multi-cycle adder/subtractor that processes WIDTH-bit operands CHUNK bits
//   per clock, LSB chunk first. The design has N = WIDTH/CHUNK chunks. After
//   the accepting edge it spends exactly N edges in RUN. It then holds the
//   result in DONE until the consumer takes it.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. The input side accepts only in IDLE (in_ready), and the output side
//   presents only in DONE (out_valid). Both ready and valid come directly from
//   the registered state. While valid is high, the data it qualifies is stable.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (A, B, Cin, sub)
//   A, B                 WIDTH-bit operands
//   Cin                  carry-in
//   sub                  0 = A+B+Cin, 1 = A-B-Cin (Cout=1 means no borrow)
//   S, Cout, ovf         result, carry-out of the MSB, signed overflow
//   out_valid/out_ready  result handshake
//   dbg_state            current FSM state (0 IDLE, 1 RUN, 2 DONE)
module serial_chunk_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;     // B already conditionally inverted for subtract
  logic              carry;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  s_q;
  logic              cout_q;
  logic              ovf_q;

  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [CHUNK:0]    csum;

  always_comb begin
    a_chunk = a_q[cnt*CHUNK +: CHUNK];
    b_chunk = b_q[cnt*CHUNK +: CHUNK];
    csum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B ^ {WIDTH{sub}};
            // Subtract is A + ~B + ~Cin, so the carry seed is Cin inverted.
            carry <= Cin ^ sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          s_q[cnt*CHUNK +: CHUNK] <= csum[CHUNK-1:0];
          carry <= csum[CHUNK];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout_q <= csum[CHUNK];
            // Carry-in XOR carry-out of the MSB is the same as this check:
            // both operands have the same sign, and the result sign differs.
            ovf_q  <= (a_chunk[CHUNK-1] == b_chunk[CHUNK-1]) &&
                      (csum[CHUNK-1] != a_chunk[CHUNK-1]);
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign S         = s_q;
  assign Cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state;

endmodule
